// File: rtl/booth_radix8_mult_if.sv
// Start/Done handshake bundle for the radix-8 Booth multiplier.
// The host drives the master side; the multiplier is the slave.
interface booth_radix8_mult_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [1:0]           state;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product, state
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product, state
  );
endinterface

// File: rtl/booth_radix8_mult.sv
// Iterative radix-8 Booth multiplier: retires three multiplier bits per STEP cycle,
// signed or unsigned per operation, behind a Start/Done handshake.
module booth_radix8_mult #(
  parameter int unsigned WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  booth_radix8_mult_if.slave bus
);

  localparam int unsigned N  = 3 * ((WIDTH + 3) / 3);
  localparam int unsigned K  = N / 3;
  localparam int unsigned AW = WIDTH + 4;
  localparam int unsigned CW = $clog2(K + 1);
  localparam logic [CW-1:0] KLast = CW'(K - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPrep = 2'b01,
    StStep = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        m_q, m3_q, acc_q;
  logic [N-1:0]         mul_q;
  logic                 lsb_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  logic                 ext_a, ext_b;
  logic [3:0]           window;
  logic [AW-1:0]        pp, sum, acc_next;
  logic [N-1:0]         mul_next;
  logic [2*WIDTH-1:0]   product_next;

  // Operands are stored already extended, so the Signed flag needs no register of its own.
  assign ext_a = bus.is_signed & bus.a[WIDTH-1];
  assign ext_b = bus.is_signed & bus.b[WIDTH-1];

  always_comb begin
    pp     = '0;
    window = {mul_q[2:0], lsb_q};
    unique case (window)
      4'd1, 4'd2, 4'd13, 4'd14: pp = m_q;
      4'd3, 4'd4, 4'd11, 4'd12: pp = m_q << 1;
      4'd5, 4'd6, 4'd9,  4'd10: pp = m3_q;
      4'd7, 4'd8:               pp = m_q << 2;
      default:                  pp = '0;
    endcase
    // Window MSB set means a negative digit (window 15 selects zero, so subtracting is harmless).
    sum          = window[3] ? (acc_q - pp) : (acc_q + pp);
    acc_next     = {{3{sum[AW-1]}}, sum[AW-1:3]};
    mul_next     = {sum[2:0], mul_q[N-1:3]};
    product_next = (2 * WIDTH)'({acc_next, mul_next});
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StPrep;
      StPrep:  state_d = StStep;
      StStep:  if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      m3_q      <= '0;
      acc_q     <= '0;
      mul_q     <= '0;
      lsb_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            m_q   <= {{4{ext_a}}, bus.a};
            mul_q <= {{(N - WIDTH){ext_b}}, bus.b};
          end
        end
        StPrep: begin
          m3_q  <= m_q + (m_q << 1);
          acc_q <= '0;
          lsb_q <= 1'b0;
          cnt_q <= KLast;
        end
        StStep: begin
          acc_q <= acc_next;
          mul_q <= mul_next;
          lsb_q <= mul_q[2];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) product_q <= product_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;
  assign bus.state   = state_q;

endmodule
